mem_stage_lsu: RTL and testbench

- MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs and issues the data-memory access.
- Drives a req/ack data-memory port, formats byte/halfword/word loads and stores, and stalls the upstream pipeline while an access is outstanding.
- Produces the registered MEM/WB payload.

---
 rtl/mem_stage_lsu.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory port, byte/half/word formatting, registered MEM/WB payload.
// Optional ack-timeout abort with a sticky bus-error flag is enabled by defining LSU_TIMEOUT_EN.
module mem_stage_lsu #(
  parameter int NB_DATA        = 32,
  parameter int NB_REG         = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic               i_mem2reg,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_regWrite,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic [NB_DATA-1:0] i_result,
  input  logic [NB_DATA-1:0] i_data4Mem,
  input  logic [NB_REG-1:0]  i_write_reg,
  output logic               o_stall,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [NB_DATA-1:0] o_mem_addr,
  output logic [3:0]         o_mem_be,
  output logic [NB_DATA-1:0] o_mem_wdata,
  input  logic               i_mem_ack,
  input  logic [NB_DATA-1:0] i_mem_rdata,
  output logic               o_valid,
  output logic               o_regWrite,
  output logic               o_mem2reg,
  output logic [NB_DATA-1:0] o_read_data,
  output logic [NB_DATA-1:0] o_alu_result,
  output logic [NB_REG-1:0]  o_write_reg,
  output logic               o_misaligned,
  output logic               o_bus_error
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  function automatic logic [3:0] calc_be(input logic [1:0] width, input logic [1:0] k);
    logic [3:0] be;
    case (width)
      2'b00:   be = 4'b0001 << k;
      2'b01:   be = k[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [NB_DATA-1:0] calc_wdata(input logic [1:0] width, input logic [NB_DATA-1:0] data);
    logic [NB_DATA-1:0] w;
    case (width)
      2'b00:   w = {4{data[7:0]}};
      2'b01:   w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  function automatic logic [NB_DATA-1:0] format_load(input logic [NB_DATA-1:0] rdata, input logic [1:0] width,
                                                     input logic [1:0] k, input logic sign);
    logic [7:0]         b;
    logic [15:0]        h;
    logic [NB_DATA-1:0] r;
    case (k)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = k[1] ? rdata[31:16] : rdata[15:0];
    case (width)
      2'b00:   r = {{(NB_DATA-8){sign & b[7]}}, b};
      2'b01:   r = {{(NB_DATA-16){sign & h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  state_t             state_r, state_nx_s;
  logic               req_we_r, req_we_nx_s;
  logic [NB_DATA-1:0] req_addr_r, req_addr_nx_s;
  logic [3:0]         req_be_r, req_be_nx_s;
  logic [NB_DATA-1:0] req_wdata_r, req_wdata_nx_s;
  logic [1:0]         ld_width_r, ld_width_nx_s;
  logic [1:0]         ld_k_r, ld_k_nx_s;
  logic               ld_sign_r, ld_sign_nx_s;
  logic               ld_regwrite_r, ld_regwrite_nx_s;
  logic               valid_r, valid_nx_s;
  logic               regwrite_r, regwrite_nx_s;
  logic               mem2reg_r, mem2reg_nx_s;
  logic [NB_DATA-1:0] read_data_r, read_data_nx_s;
  logic [NB_DATA-1:0] alu_result_r, alu_result_nx_s;
  logic [NB_REG-1:0]  write_reg_r, write_reg_nx_s;
  logic               misaligned_r, misaligned_nx_s;
  logic               mem_op_s, misaligned_s, timeout_hit_s, stall_s;

  assign mem_op_s     = i_memRead | i_memWrite;
  assign misaligned_s = mem_op_s & (((i_width == 2'b01) & i_result[0]) |
                                    (i_width[1] & (i_result[1:0] != 2'b00)));

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] count_r, count_nx_s;
  logic             bus_error_r, bus_error_nx_s;

  assign timeout_hit_s = (state_r == REQ) & ~i_mem_ack & (count_r == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_bus_error   = bus_error_r;

  // Timeout counter and sticky bus-error register.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      count_r     <= '0;
      bus_error_r <= 1'b0;
    end else begin
      count_r     <= count_nx_s;
      bus_error_r <= bus_error_nx_s;
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES == 32'sd0);
  assign timeout_hit_s    = 1'b0;
  assign o_bus_error      = 1'b0;
`endif

  // Next-state, request capture and MEM/WB payload selection; every register holds by default.
  always_comb begin
    state_nx_s       = state_r;
    req_we_nx_s      = req_we_r;
    req_addr_nx_s    = req_addr_r;
    req_be_nx_s      = req_be_r;
    req_wdata_nx_s   = req_wdata_r;
    ld_width_nx_s    = ld_width_r;
    ld_k_nx_s        = ld_k_r;
    ld_sign_nx_s     = ld_sign_r;
    ld_regwrite_nx_s = ld_regwrite_r;
    valid_nx_s       = valid_r;
    regwrite_nx_s    = regwrite_r;
    mem2reg_nx_s     = mem2reg_r;
    read_data_nx_s   = read_data_r;
    alu_result_nx_s  = alu_result_r;
    write_reg_nx_s   = write_reg_r;
    misaligned_nx_s  = misaligned_r;
    stall_s          = 1'b0;
`ifdef LSU_TIMEOUT_EN
    count_nx_s       = count_r;
    bus_error_nx_s   = bus_error_r;
`endif
    case (state_r)
      IDLE: begin
        if (i_halt) begin
          stall_s = 1'b0;
        end else begin
          valid_nx_s      = 1'b1;
          regwrite_nx_s   = i_regWrite;
          mem2reg_nx_s    = i_mem2reg;
          alu_result_nx_s = i_result;
          write_reg_nx_s  = i_write_reg;
          read_data_nx_s  = '0;
          misaligned_nx_s = misaligned_s;
          if (misaligned_s) begin
            regwrite_nx_s = 1'b0;
          end else if (mem_op_s) begin
            // Aligned access: launch the request and emit a bubble meanwhile.
            stall_s          = 1'b1;
            state_nx_s       = REQ;
            valid_nx_s       = 1'b0;
            regwrite_nx_s    = 1'b0;
            req_we_nx_s      = i_memWrite;
            req_addr_nx_s    = {i_result[NB_DATA-1:2], 2'b00};
            req_be_nx_s      = calc_be(i_width, i_result[1:0]);
            req_wdata_nx_s   = calc_wdata(i_width, i_data4Mem);
            ld_width_nx_s    = i_width;
            ld_k_nx_s        = i_result[1:0];
            ld_sign_nx_s     = i_sign_flag;
            ld_regwrite_nx_s = i_regWrite;
`ifdef LSU_TIMEOUT_EN
            count_nx_s       = '0;
`endif
          end else begin
            stall_s = 1'b0;
          end
        end
      end
      REQ: begin
        stall_s = ~i_mem_ack & ~timeout_hit_s;
        if (i_mem_ack) begin
          state_nx_s     = IDLE;
          valid_nx_s     = 1'b1;
          regwrite_nx_s  = ld_regwrite_r;
          read_data_nx_s = req_we_r ? '0 : format_load(i_mem_rdata, ld_width_r, ld_k_r, ld_sign_r);
        end else if (timeout_hit_s) begin
          state_nx_s     = IDLE;
          valid_nx_s     = 1'b1;
          regwrite_nx_s  = 1'b0;
          read_data_nx_s = '0;
`ifdef LSU_TIMEOUT_EN
          bus_error_nx_s = 1'b1;
`endif
        end else begin
          state_nx_s = REQ;
`ifdef LSU_TIMEOUT_EN
          count_nx_s = count_r + 1'b1;
`endif
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, request and MEM/WB payload registers.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r       <= IDLE;
      req_we_r      <= 1'b0;
      req_addr_r    <= '0;
      req_be_r      <= 4'b0000;
      req_wdata_r   <= '0;
      ld_width_r    <= 2'b00;
      ld_k_r        <= 2'b00;
      ld_sign_r     <= 1'b0;
      ld_regwrite_r <= 1'b0;
      valid_r       <= 1'b0;
      regwrite_r    <= 1'b0;
      mem2reg_r     <= 1'b0;
      read_data_r   <= '0;
      alu_result_r  <= '0;
      write_reg_r   <= '0;
      misaligned_r  <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      req_we_r      <= req_we_nx_s;
      req_addr_r    <= req_addr_nx_s;
      req_be_r      <= req_be_nx_s;
      req_wdata_r   <= req_wdata_nx_s;
      ld_width_r    <= ld_width_nx_s;
      ld_k_r        <= ld_k_nx_s;
      ld_sign_r     <= ld_sign_nx_s;
      ld_regwrite_r <= ld_regwrite_nx_s;
      valid_r       <= valid_nx_s;
      regwrite_r    <= regwrite_nx_s;
      mem2reg_r     <= mem2reg_nx_s;
      read_data_r   <= read_data_nx_s;
      alu_result_r  <= alu_result_nx_s;
      write_reg_r   <= write_reg_nx_s;
      misaligned_r  <= misaligned_nx_s;
    end
  end

  // The request line comes straight off the state register, so reset drops it asynchronously.
  assign o_stall      = i_reset & stall_s;
  assign o_mem_req    = (state_r == REQ);
  assign o_mem_we     = req_we_r;
  assign o_mem_addr   = req_addr_r;
  assign o_mem_be     = req_be_r;
  assign o_mem_wdata  = req_wdata_r;
  assign o_valid      = valid_r;
  assign o_regWrite   = regwrite_r;
  assign o_mem2reg    = mem2reg_r;
  assign o_read_data  = read_data_r;
  assign o_alu_result = alu_result_r;
  assign o_write_reg  = write_reg_r;
  assign o_misaligned = misaligned_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Table-driven bench for mem_stage_lsu plus directed sequences for halt, reset and ack timeout.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n, halt, mem2reg, mem_read, mem_write, reg_write, sign, ack;
  logic [1:0]  width;
  logic [31:0] result, data, rdata;
  logic [4:0]  wreg;
  logic        o_stall, o_mem_req, o_mem_we, o_valid, o_regWrite, o_mem2reg, o_misaligned, o_bus_error;
  logic [31:0] o_mem_addr, o_mem_wdata, o_read_data, o_alu_result;
  logic [3:0]  o_mem_be;
  logic [4:0]  o_write_reg;
  int          n_checks = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .i_reset(rst_n), .i_halt(halt), .i_mem2reg(mem2reg), .i_memRead(mem_read),
    .i_memWrite(mem_write), .i_regWrite(reg_write), .i_width(width), .i_sign_flag(sign),
    .i_result(result), .i_data4Mem(data), .i_write_reg(wreg), .o_stall(o_stall),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(ack), .i_mem_rdata(rdata), .o_valid(o_valid),
    .o_regWrite(o_regWrite), .o_mem2reg(o_mem2reg), .o_read_data(o_read_data),
    .o_alu_result(o_alu_result), .o_write_reg(o_write_reg), .o_misaligned(o_misaligned),
    .o_bus_error(o_bus_error)
  );

  typedef struct {
    logic        rd, wr, rw, m2r;
    logic [1:0]  width;
    logic        sign;
    logic [31:0] addr, data, rdata;
    int          delay;
    logic        exp_req, exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_read;
    logic        exp_rw, exp_mis;
    int          exp_stalls;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; mem2reg = 1'b0; width = 2'b00;
    sign = 1'b0; result = 32'h0; data = 32'h0; wreg = 5'd0; ack = 1'b0; rdata = 32'h0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int stalls;
    stalls = 0;
    mem_read = v.rd; mem_write = v.wr; reg_write = v.rw; mem2reg = v.m2r; width = v.width;
    sign = v.sign; result = v.addr; data = v.data; wreg = 5'(idx + 1); ack = 1'b0; rdata = 32'h0;
    #1;
    if (o_stall) stalls++;
    chk($sformatf("v%0d.req_issue", idx), {31'd0, o_mem_req}, 32'd0);
    if (v.exp_req) begin
      @(posedge clk); #1;
      chk($sformatf("v%0d.req", idx), {31'd0, o_mem_req}, 32'd1);
      chk($sformatf("v%0d.we", idx), {31'd0, o_mem_we}, {31'd0, v.exp_we});
      chk($sformatf("v%0d.addr", idx), o_mem_addr, v.exp_addr);
      chk($sformatf("v%0d.be", idx), {28'd0, o_mem_be}, {28'd0, v.exp_be});
      if (v.exp_we) chk($sformatf("v%0d.wdata", idx), o_mem_wdata, v.exp_wdata);
      for (int c = 0; c <= v.delay; c++) begin
        if (c == v.delay) begin
          ack = 1'b1; rdata = v.rdata;
        end else begin
          ack = 1'b0; rdata = 32'hDEAD_0000 | 32'(c);
        end
        #1;
        if (o_stall) stalls++;
        if (c < v.delay) begin
          @(posedge clk); #1;
        end
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    chk($sformatf("v%0d.stalls", idx), 32'(stalls), 32'(v.exp_stalls));
    chk($sformatf("v%0d.valid", idx), {31'd0, o_valid}, 32'd1);
    chk($sformatf("v%0d.regWrite", idx), {31'd0, o_regWrite}, {31'd0, v.exp_rw});
    chk($sformatf("v%0d.misaligned", idx), {31'd0, o_misaligned}, {31'd0, v.exp_mis});
    chk($sformatf("v%0d.req_done", idx), {31'd0, o_mem_req}, 32'd0);
    if (!v.exp_mis) begin
      chk($sformatf("v%0d.read_data", idx), o_read_data, v.exp_read);
      chk($sformatf("v%0d.mem2reg", idx), {31'd0, o_mem2reg}, {31'd0, v.m2r});
      chk($sformatf("v%0d.alu_result", idx), o_alu_result, v.addr);
      chk($sformatf("v%0d.write_reg", idx), {27'd0, o_write_reg}, 32'(idx + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //           rd    wr    rw    m2r   width  sign  addr           data           rdata          dly req   we    exp_addr    be       wdata          read           rw    mis  stalls
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 32'h0000_0103, 32'h0,         32'h80AA_BBCC, 0, 1'b1, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b1, 1'b0, 1};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0,         32'h8001_1234, 3, 1'b1, 1'b0, 32'h0000_0200, 4'b1100, 32'h0,         32'h0000_8001, 1'b1, 1'b0, 4};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h1234_56AB, 32'hDEAD_BEEF, 0, 1'b1, 1'b1, 32'h0000_0010, 4'b0010, 32'hABAB_ABAB, 32'h0,         1'b0, 1'b0, 1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0006, 32'h0,         32'h0,         0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b0, 1'b1, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'hCAFE_0001, 32'h5555_5555, 32'h0,         0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 1'b0, 0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 32'h0000_0040, 32'h0,         32'h89AB_CDEF, 1, 1'b1, 1'b0, 32'h0000_0040, 4'b1111, 32'h0,         32'h89AB_CDEF, 1'b1, 1'b0, 2};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_BEEF, 32'h0,         2, 1'b1, 1'b1, 32'h0000_0020, 4'b1100, 32'hBEEF_BEEF, 32'h0,         1'b0, 1'b0, 3};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 32'h0000_0300, 32'h0,         32'h1234_F00D, 0, 1'b1, 1'b0, 32'h0000_0300, 4'b0011, 32'h0,         32'hFFFF_F00D, 1'b1, 1'b0, 1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0102_0304, 32'h0,         0, 1'b1, 1'b1, 32'h0000_0044, 4'b1111, 32'h0102_0304, 32'h0,         1'b0, 1'b0, 1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0501, 32'h0,         32'h0000_9A00, 0, 1'b1, 1'b0, 32'h0000_0500, 4'b0010, 32'h0,         32'h0000_009A, 1'b1, 1'b0, 1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 32'h0000_000B, 32'h0,         32'h0,         0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b0, 1'b1, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 32'h0000_0102, 32'h0,         32'h0071_0000, 0, 1'b1, 1'b0, 32'h0000_0100, 4'b0100, 32'h0,         32'h0000_0071, 1'b1, 1'b0, 1};

    rst_n = 1'b0; halt = 1'b0;
    idle_inputs();
    #3;
    chk("rst.req", {31'd0, o_mem_req}, 32'd0);
    chk("rst.valid", {31'd0, o_valid}, 32'd0);
    chk("rst.regWrite", {31'd0, o_regWrite}, 32'd0);
    chk("rst.read_data", o_read_data, 32'd0);
    chk("rst.alu_result", o_alu_result, 32'd0);
    chk("rst.bus_error", {31'd0, o_bus_error}, 32'd0);
    chk("rst.stall", {31'd0, o_stall}, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Misaligned pulse lasts one cycle.
    mem_read = 1'b1; width = 2'b11; reg_write = 1'b1; result = 32'h0000_0006;
    @(posedge clk); #1;
    chk("mis.pulse", {31'd0, o_misaligned}, 32'd1);
    idle_inputs(); reg_write = 1'b1; result = 32'h0000_0077;
    @(posedge clk); #1;
    chk("mis.clear", {31'd0, o_misaligned}, 32'd0);
    chk("mis.next_alu", o_alu_result, 32'h0000_0077);

    // Halt in IDLE freezes everything and blocks the request.
    halt = 1'b1; mem_read = 1'b1; width = 2'b11; reg_write = 1'b0; result = 32'h0000_0080;
    #1;
    chk("halt_idle.stall", {31'd0, o_stall}, 32'd0);
    @(posedge clk); #1;
    chk("halt_idle.req", {31'd0, o_mem_req}, 32'd0);
    chk("halt_idle.alu_hold", o_alu_result, 32'h0000_0077);
    chk("halt_idle.rw_hold", {31'd0, o_regWrite}, 32'd1);
    halt = 1'b0;
    #1;
    chk("halt_rel.stall", {31'd0, o_stall}, 32'd1);
    @(posedge clk); #1;
    chk("halt_rel.req", {31'd0, o_mem_req}, 32'd1);

    // Halt during REQ is ignored until the access completes.
    halt = 1'b1; ack = 1'b1; rdata = 32'h1357_9BDF;
    #1;
    chk("halt_req.stall", {31'd0, o_stall}, 32'd0);
    @(posedge clk); #1;
    ack = 1'b0;
    chk("halt_req.done", {31'd0, o_mem_req}, 32'd0);
    chk("halt_req.valid", {31'd0, o_valid}, 32'd1);
    chk("halt_req.read", o_read_data, 32'h1357_9BDF);
    @(posedge clk); #1;
    chk("halt_req.after", {31'd0, o_mem_req}, 32'd0);
    halt = 1'b0; idle_inputs();
    @(posedge clk); #1;

    // Long ack wait: abort with timeout feature, otherwise wait indefinitely.
    mem_read = 1'b1; width = 2'b11; reg_write = 1'b1; result = 32'h0000_0200;
    @(posedge clk); #1;
`ifdef LSU_TIMEOUT_EN
    begin
      int cyc;
      cyc = 0;
      while (o_mem_req && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("tmo.req_cycles", 32'(cyc), 32'd16);
      chk("tmo.bus_error", {31'd0, o_bus_error}, 32'd1);
      chk("tmo.valid", {31'd0, o_valid}, 32'd1);
      chk("tmo.regWrite", {31'd0, o_regWrite}, 32'd0);
      chk("tmo.read", o_read_data, 32'd0);
      idle_inputs(); reg_write = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("tmo.sticky", {31'd0, o_bus_error}, 32'd1);
    end
`else
    repeat (20) @(posedge clk);
    #1;
    chk("wait.req", {31'd0, o_mem_req}, 32'd1);
    chk("wait.stall", {31'd0, o_stall}, 32'd1);
    chk("wait.bus_error", {31'd0, o_bus_error}, 32'd0);
    ack = 1'b1; rdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    idle_inputs();
    chk("wait.done", {31'd0, o_mem_req}, 32'd0);
    chk("wait.read", o_read_data, 32'h0BAD_F00D);
`endif

    // Reset mid-REQ drops the request asynchronously.
    mem_read = 1'b1; width = 2'b11; reg_write = 1'b1; result = 32'h0000_0400; wreg = 5'd9;
    @(posedge clk); #1;
    chk("rstreq.req_before", {31'd0, o_mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstreq.req", {31'd0, o_mem_req}, 32'd0);
    chk("rstreq.stall", {31'd0, o_stall}, 32'd0);
    chk("rstreq.valid", {31'd0, o_valid}, 32'd0);
    chk("rstreq.alu", o_alu_result, 32'd0);
    chk("rstreq.addr", o_mem_addr, 32'd0);
    chk("rstreq.bus_error", {31'd0, o_bus_error}, 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    reg_write = 1'b1; result = 32'h0000_0099;
    @(posedge clk); #1;
    chk("rstreq.idle_req", {31'd0, o_mem_req}, 32'd0);
    chk("rstreq.pass_valid", {31'd0, o_valid}, 32'd1);
    chk("rstreq.pass_alu", o_alu_result, 32'h0000_0099);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
